// File: rtl/division_result_display.sv
// Display stage for the 4-bit divider: latches quotient/remainder on a done edge
// and scans them as two decimal pairs across a 4-digit multiplexed 7-segment display.
module division_result_display #(
    parameter int REFRESH_DIV   = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       done,
    input  logic [3:0] quotient,
    input  logic [4:0] remainder,
    output logic [6:0] seg,
    output logic [3:0] digit,
    output logic       shown
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_SHOW = 2'd2;

    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

    logic [1:0]    state;
    logic          done_q;
    logic [3:0]    cap_q;
    logic [4:0]    cap_r;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          tick;

    logic          q_tens;
    logic [3:0]    q_units;
    logic [1:0]    r_tens;
    logic [4:0]    r_sub;
    logic [3:0]    r_units;
    logic [6:0]    nxt_seg;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = GLYPH_BLANK;
        endcase
    endfunction

    // Decimal split by threshold compare; ranges are small enough to avoid a divider.
    assign q_tens  = (cap_q >= 4'd10);
    assign q_units = cap_q - (q_tens ? 4'd10 : 4'd0);

    always_comb begin
        r_tens = 2'd0;
        r_sub  = 5'd0;
        if (cap_r >= 5'd30) begin
            r_tens = 2'd3;
            r_sub  = 5'd30;
        end else if (cap_r >= 5'd20) begin
            r_tens = 2'd2;
            r_sub  = 5'd20;
        end else if (cap_r >= 5'd10) begin
            r_tens = 2'd1;
            r_sub  = 5'd10;
        end
    end

    assign r_units = 4'(cap_r - r_sub);

    // idx names the digit that the next tick will light.
    always_comb begin
        nxt_seg = GLYPH_BLANK;
        case (state)
            S_WAIT: nxt_seg = GLYPH_DASH;
            S_SHOW: begin
                case (idx)
                    2'd3:    nxt_seg = (BLANK_LEADING && !q_tens) ? GLYPH_BLANK : glyph({3'b000, q_tens});
                    2'd2:    nxt_seg = glyph(q_units);
                    2'd1:    nxt_seg = (BLANK_LEADING && r_tens == 2'd0) ? GLYPH_BLANK : glyph({2'b00, r_tens});
                    default: nxt_seg = glyph(r_units);
                endcase
            end
            default: nxt_seg = GLYPH_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
            cap_q  <= 4'd0;
            cap_r  <= 5'd0;
        end else begin
            done_q <= done;
            if (start) begin
                state <= S_WAIT;
            end else if (done && !done_q) begin
                state <= S_SHOW;
                cap_q <= quotient;
                cap_r <= remainder;
            end
        end
    end

    assign tick = (cnt == TC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            idx   <= 2'd0;
            seg   <= GLYPH_BLANK;
            digit <= 4'hF;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx   <= idx + 2'd1;
                digit <= ~(4'b0001 << idx);
                seg   <= nxt_seg;
            end
        end
    end

    assign shown = (state == S_SHOW);

endmodule

// File: tb/tb_division_result_display.sv
// Randomized checks of the divider result display against a decimal reference model.
module tb_division_result_display;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       done;
    logic [3:0] quotient;
    logic [4:0] remainder;
    logic [6:0] seg;
    logic [3:0] digit;
    logic       shown;

    int tests = 0;
    int fails = 0;
    int ec;

    // reference model: 0 idle, 1 waiting, 2 showing
    int mstate;
    int mq, mr;
    logic mdq;

    division_result_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .quotient(quotient), .remainder(remainder),
        .seg(seg), .digit(digit), .shown(shown)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) ec <= 0;
        else      ec <= ec + 1;
    end

    function automatic logic [6:0] num_glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int pos);
        int v;
        if (mstate == 0) return 7'h7F;
        if (mstate == 1) return 7'b0111111;
        v = (pos >= 2) ? mq : mr;
        if (pos == 3 || pos == 1) return (v / 10 == 0) ? 7'h7F : num_glyph(v / 10);
        return num_glyph(v % 10);
    endfunction

    task automatic step(input logic s, input logic d, input int q, input int r);
        @(negedge clk);
        start = s; done = d; quotient = 4'(q); remainder = 5'(r);
        @(posedge clk);
        if (s) mstate = 1;
        else if (d && !mdq) begin
            mstate = 2; mq = q; mr = r;
        end
        mdq = d;
        #1;
        tests++;
        if (shown !== (mstate == 2)) begin
            fails++;
            $display("FAIL step_shown: got %b want %b", shown, mstate == 2);
        end
        start = 1'b0;
    endtask

    task automatic check_scan(input string nm);
        int seen = 0;
        int guard = 0;
        int pos;
        logic [3:0] ed;
        logic [6:0] es;
        while (seen < 5 && guard < 40) begin
            @(negedge clk);
            guard++;
            tests++;
            if (shown !== (mstate == 2)) begin
                fails++;
                $display("FAIL %s_shown: got %b want %b", nm, shown, mstate == 2);
            end
            if (ec >= 4 && ec % 4 == 0) begin
                seen++;
                if (seen > 1) begin
                    pos = (ec / 4 - 1) % 4;
                    ed  = ~(4'b0001 << pos);
                    es  = exp_seg(pos);
                    tests++;
                    if (digit !== ed || seg !== es) begin
                        fails++;
                        $display("FAIL %s_pos%0d: digit %b seg %b, want digit %b seg %b", nm, pos, digit, seg, ed, es);
                    end
                end
            end
        end
        tests++;
        if (seen < 5) begin
            fails++;
            $display("FAIL %s_timeout: saw %0d ticks, want 5", nm, seen);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; done = 1'b0; quotient = '0; remainder = '0;
        mstate = 0; mq = 0; mr = 0; mdq = 1'b0;
        #12;
        tests++;
        if (seg !== 7'h7F || digit !== 4'hF || shown !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: seg %h digit %h shown %b, want 7f f 0", seg, digit, shown);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            tests++;
            if (k < 4 && digit !== 4'hF) begin
                fails++;
                $display("FAIL reset_pre_tick%0d: digit %b want 1111", k, digit);
            end else if (k == 4 && (digit !== 4'b1110 || seg !== 7'h7F)) begin
                fails++;
                $display("FAIL reset_first_tick: digit %b seg %b want 1110 1111111", digit, seg);
            end
        end
        check_scan("reset_scan");
    endtask

    task automatic test_wait();
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        check_scan("wait_dash");
    endtask

    task automatic test_show();
        step(1'b0, 1'b1, 1, 0);
        check_scan("show_1_0");
        step(1'b0, 1'b0, 1, 0);
        step(1'b0, 1'b1, 12, 17);
        check_scan("show_12_17");
        step(1'b0, 1'b1, 3, 1);
        check_scan("held_done");
    endtask

    task automatic test_start_wins();
        step(1'b0, 1'b0, 3, 1);
        step(1'b1, 1'b1, 3, 1);
        check_scan("start_wins");
        step(1'b0, 1'b0, 3, 1);
        step(1'b0, 1'b1, 3, 1);
        check_scan("show_3_1");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #1 rst = 1'b0; done = 1'b0; start = 1'b0;
        #1;
        tests++;
        if (seg !== 7'h7F || digit !== 4'hF || shown !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: seg %h digit %h shown %b, want 7f f 0", seg, digit, shown);
        end
        #2 rst = 1'b1;
        mstate = 0; mq = 0; mr = 0; mdq = 1'b0;
        check_scan("post_reset_idle");
        step(1'b0, 1'b1, 2, 2);
        check_scan("show_2_2");
    endtask

    task automatic test_random();
        int q, r;
        logic s, d;
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 3; j++) begin
                q = $urandom_range(15);
                r = $urandom_range(31);
                s = ($urandom_range(4) == 0);
                d = $urandom_range(1);
                step(s, d, q, r);
            end
            check_scan("random");
        end
    endtask

    initial begin
        test_reset();
        test_wait();
        test_show();
        test_start_wins();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/division_result_display.md
# division_result_display

Downstream display stage for the 4-bit restoring divider: it captures the divider's `quotient`/`remainder` when `done` rises and shows them on a 4-digit multiplexed 7-segment display. The left two digits show the decimal quotient and the right two the decimal remainder. The block drives the board-level `seg`/`digit` pins that the divider top level leaves unconnected. While a division is in flight it shows dashes.

## Interface
- `REFRESH_DIV`, 50000: clock cycles each digit stays enabled per scan step (≥2).
- `BLANK_LEADING`, 1: 1 blanks the tens digit of a pair when it is zero.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  same start pulse that is fed to the divider.
- `done`  in  1  divider done flag; its level may be held.
- `quotient`  in  4  divider quotient, 0–15.
- `remainder`  in  5  divider remainder, 0–31; all values are displayed.
- `seg`  out  7  segments, active-low, `seg[6:0]` = g f e d c b a.
- `digit`  out  4  digit enables, active-low; `digit[3]` = quotient tens, `[2]` = quotient units, `[1]` = remainder tens, `[0]` = remainder units.
- `shown`  out  1  high while a captured result is displayed.

## Operation
- States:
  - IDLE: all digits blank.
  - WAIT: all digits show dash, `seg`=7'b0111111.
  - SHOW: captured result is displayed.
- Transitions:
  - `start`=1 → WAIT from any state.
  - Rising edge of `done` (current `done`=1, registered `done_q`=0) with `start`=0 → capture `quotient`/`remainder`, go to SHOW.
  - All other cycles hold state.
- Simultaneous `start` and `done` edge: `start` wins. Go to WAIT, capture nothing.
- `done` held high does not recapture. The captured registers are unaffected by later input changes until the next `done` edge.
- A `done` edge is accepted from IDLE, WAIT or SHOW.
- Binary-to-decimal conversion: tens = value ≥ 10/20/30, units = value − 10·tens. This is combinational on the captured registers; no division operator.
  - Quotient tens is 0–1.
  - Remainder tens is 0–3.
- Glyph patterns, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
- Leading blanking applies only in SHOW, only to the tens digits, and only when `BLANK_LEADING`=1. The units digits always show a numeral.
- `shown` = 1 exactly in SHOW.

## Timing
- Reset values (asserted asynchronously while `rst`=0):
  - state=IDLE, `seg`=7'h7F, `digit`=4'hF, `shown`=0.
  - Refresh counter 0, scan index 0, `done_q`=0, captured quotient and remainder 0.
- Refresh counter counts 0..REFRESH_DIV−1 and wraps. The terminal-count cycle is the "tick".
- On each tick edge the scan index advances 3→0→1→2→3 (mod 4). In the same edge, `digit` enables the new index (one bit low) and `seg` is loaded with that digit's glyph. Both are registered, so they never glitch.
- The first tick after reset release occurs on the REFRESH_DIV-th rising edge. From that edge on, `digit`=4'b1110.
- State and capture update on the edge that samples the event. `shown` changes on that same edge.
- `seg` reflects new content at the next tick. The worst-case display latency is REFRESH_DIV cycles.
- Reset asserted mid-SHOW or mid-WAIT returns all outputs to their reset values immediately. The captured result is lost.
- The scan continues in every state. In IDLE every digit is enabled in turn with a blank glyph.

## Test plan
Use `REFRESH_DIV`=4 and `BLANK_LEADING`=1 in all scenarios.
1. Reset:
   - Hold `rst`=0 → `seg`=7'h7F, `digit`=4'hF, `shown`=0.
   - Release → `digit` unchanged until the 4th edge, then `digit`=4'b1110 with `seg`=7'h7F. The scan then cycles 1101, 1011, 0111 every 4 cycles.
2. `start` pulse for 2 cycles → WAIT. At every tick `seg`=7'b0111111 on all four digits, `shown`=0.
3. 15/15: `quotient`=1, `remainder`=0, `done` rises → `shown`=1 on the next edge. Per digit:
   - `digit[3]` blank (7'h7F).
   - `digit[2]` = 7'b1111001.
   - `digit[1]` blank.
   - `digit[0]` = 7'b1000000.
4. `quotient`=12, `remainder`=17, `done` edge → digits 3..0 = 1111001, 0100100, 1111001, 1111000. Then change inputs to 7/2 (3, 1) with `done` held high → display unchanged.
5. `start` and a `done` rising edge in the same cycle while in SHOW → state WAIT (dashes), `shown`=0. A later `done` edge with 7/2 → digits show blank, 3 (0110000), blank, 1 (1111001).
6. In SHOW, pulse `rst` low for 3 ns between clock edges → all outputs at reset values asynchronously. After release the state is IDLE (blank) and a `done` edge with 8/3 (2, 2) displays 2 and 2 correctly.
